// File: rtl/sram_frame_reader_pkg.sv
// Shared definitions for the raster-scan frame SRAM reader.
//   - Image/SRAM geometry defaults shared with the frame SRAM.
//   - FSM state encoding.
//   - Bit positions of the pixel tags {eof, eol, sof} stored above the pixel
//     value in each output FIFO entry.
package sram_frame_reader_pkg;

   localparam int IMG_W_DEF      = 1024;
   localparam int IMG_H_DEF      = 1024;
   localparam int ADDR_SZ_DEF    = 20;
   localparam int RAM_WIDTH_DEF  = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int TAG_SOF = 0;
   localparam int TAG_EOL = 1;
   localparam int TAG_EOF = 2;
   localparam int TAG_W   = 3;

   // Counter width that stays legal for a dimension of 1.
   function automatic int cnt_w(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

endpackage

// File: rtl/sram_frame_reader_sync_fifo.sv
// Synchronous FIFO (registered head, not fall-through) used as the output
// buffer of sram_frame_reader.
// Ports:
//   clk, rst_n      clock, async active-low reset (empties the FIFO)
//   push, wdata     write request and data; ignored when full unless popping
//   pop             read request; ignored when empty
//   rdata           head entry
//   count           occupancy (0..DEPTH)
//   full, empty     occupancy flags
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sram_frame_reader.sv
// Raster-scan read controller for the frame SRAM. A start pulse reads the
// whole frame, one SRAM read per pixel, and streams pixels over valid/ready
// with sof/eol/eof markers. Reads are only issued when the output FIFO is
// guaranteed to have room for them, so backpressure never loses data.
//
// Optional build macro SRAM_FRAME_READER_HFLIP_EN adds input hflip: when set
// at start, each line is read right-to-left; tags follow output order.
//
// Ports:
//   clk, rst_n          clock, async active-low reset (abandons any frame)
//   start               frame request, sampled only in IDLE
//   hflip               (macro only) mirror lines horizontally
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   sram_en, sram_we    SRAM read enable, write enable (always 0)
//   sram_addr           SRAM read address
//   sram_data           SRAM read data, valid the cycle after sram_en
//   pix_data/valid      output pixel stream
//   pix_ready           consumer accept
//   pix_sof/eol/eof     frame/line markers of the current pixel
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; no reads
// ST_READ  | issuing reads in raster order, throttled by FIFO credit
// ST_DRAIN | all reads issued; waiting for the eof pixel to handshake
module sram_frame_reader
   import sram_frame_reader_pkg::*;
#(
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int ADDR_SZ    = ADDR_SZ_DEF,
   parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
`ifdef SRAM_FRAME_READER_HFLIP_EN
   input  logic                 hflip,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 sram_en,
   output logic                 sram_we,
   output logic [ADDR_SZ-1:0]   sram_addr,
   input  logic [RAM_WIDTH-1:0] sram_data,
   output logic [RAM_WIDTH-1:0] pix_data,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic                 pix_sof,
   output logic                 pix_eol,
   output logic                 pix_eof
);

   localparam int XW = cnt_w(IMG_W);
   localparam int YW = cnt_w(IMG_H);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int FW = RAM_WIDTH + TAG_W;

   state_t state;
   state_t state_nxt;

   logic [XW-1:0]      x;
   logic [YW-1:0]      y;
   logic [ADDR_SZ-1:0] base;
   logic [XW-1:0]      col;
   logic               last_x;
   logic               last_y;

   logic               issue;
   logic               done_c;
   logic               room;
   logic [CW:0]        occ;

   // One read in flight between issue and FIFO write; its tags ride along.
   logic               rd_vld;
   logic [TAG_W-1:0]   rd_tag;

   logic [FW-1:0]      fifo_rdata;
   logic [CW-1:0]      fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop_eof;

   assign last_x = (x == XW'(IMG_W - 1));
   assign last_y = (y == YW'(IMG_H - 1));

`ifdef SRAM_FRAME_READER_HFLIP_EN
   logic hflip_q;
   assign col = hflip_q ? (XW'(IMG_W - 1) - x) : x;
`else
   assign col = x;
`endif

   // Credit: FIFO occupancy plus the read still in the SRAM pipe.
   assign occ     = {1'b0, fifo_count} + (CW+1)'(rd_vld);
   assign room    = !fifo_full && (occ < (CW+1)'(FIFO_DEPTH));
   assign pop_eof = !fifo_empty && pix_ready && fifo_rdata[RAM_WIDTH+TAG_EOF];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_READ;
         end
         ST_READ: begin
            issue = room;
            if (room && last_x && last_y) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            done_c = pop_eof;
            if (pop_eof) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Raster position with a running line base so no multiplier is needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x    <= '0;
         y    <= '0;
         base <= '0;
`ifdef SRAM_FRAME_READER_HFLIP_EN
         hflip_q <= 1'b0;
`endif
      end else if (state == ST_IDLE && start) begin
         x    <= '0;
         y    <= '0;
         base <= '0;
`ifdef SRAM_FRAME_READER_HFLIP_EN
         hflip_q <= hflip;
`endif
      end else if (issue) begin
         if (last_x) begin
            x <= '0;
            if (last_y) begin
               y    <= '0;
               base <= '0;
            end else begin
               y    <= y + YW'(1);
               base <= base + ADDR_SZ'(IMG_W);
            end
         end else begin
            x <= x + XW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_vld <= 1'b0;
         rd_tag <= '0;
      end else begin
         rd_vld <= issue;
         rd_tag <= {last_x && last_y, last_x, (x == '0) && (y == '0)};
      end
   end

   sync_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_vld),
      .wdata ({rd_tag, sram_data}),
      .pop   (pix_ready),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign busy      = (state != ST_IDLE);
   assign done      = done_c;
   assign sram_en   = issue;
   assign sram_we   = 1'b0;
   assign sram_addr = (state == ST_READ) ? (base + ADDR_SZ'(col)) : '0;

   // Gate the head entry so an empty FIFO presents all-zero outputs.
   assign pix_valid = !fifo_empty;
   assign pix_data  = fifo_empty ? '0 : fifo_rdata[RAM_WIDTH-1:0];
   assign pix_sof   = !fifo_empty && fifo_rdata[RAM_WIDTH+TAG_SOF];
   assign pix_eol   = !fifo_empty && fifo_rdata[RAM_WIDTH+TAG_EOL];
   assign pix_eof   = !fifo_empty && fifo_rdata[RAM_WIDTH+TAG_EOF];

endmodule

// File: tb/tb_sram_frame_reader.sv
// Self-checking bench for sram_frame_reader on a 4x3 frame with an SRAM
// model preloaded mem[i]=i. A per-cycle monitor checks the stream against a
// reference built from raster arithmetic and read/pop counts.
module tb_sram_frame_reader;

   localparam int W     = 4;
   localparam int H     = 3;
   localparam int AS    = 20;
   localparam int RW    = 8;
   localparam int DEPTH = 4;
   localparam int NPIX  = W * H;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          busy;
   logic          done;
   logic          sram_en;
   logic          sram_we;
   logic [AS-1:0] sram_addr;
   logic [RW-1:0] sram_data;
   logic [RW-1:0] pix_data;
   logic          pix_valid;
   logic          pix_ready;
   logic          pix_sof;
   logic          pix_eol;
   logic          pix_eof;
`ifdef SRAM_FRAME_READER_HFLIP_EN
   logic          hflip;
`endif

   sram_frame_reader #(
      .IMG_W(W), .IMG_H(H), .ADDR_SZ(AS), .RAM_WIDTH(RW), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
`ifdef SRAM_FRAME_READER_HFLIP_EN
      .hflip(hflip),
`endif
      .busy(busy), .done(done), .sram_en(sram_en), .sram_we(sram_we),
      .sram_addr(sram_addr), .sram_data(sram_data), .pix_data(pix_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof),
      .pix_eol(pix_eol), .pix_eof(pix_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [RW-1:0] mem [0:1023];
   always @(posedge clk) if (sram_en) sram_data <= mem[sram_addr[9:0]];

   int vectors    = 0;
   int miscompares = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model state
   bit            mon_on = 1'b0;
   bit            hf = 1'b0;
   int            issued, popped, done_cnt, done_cyc, cur_cyc;
   bit            prev_done, prev_stall;
   logic [RW+2:0] prev_word;

   function automatic int exp_addr(input int k);
      int xx, yy;
      xx = k % W;
      yy = k / W;
      return yy * W + (hf ? (W - 1 - xx) : xx);
   endfunction

   always @(negedge clk) begin
      if (mon_on) begin : mon
         logic [RW+2:0] word, expw;
         int k;
         word = {pix_eof, pix_eol, pix_sof, pix_data};
         check("sram_we", sram_we, 0);
         check("sram_en", sram_en, busy && issued < NPIX && (issued - popped) < DEPTH);
         if (sram_en) begin
            if (issued < NPIX) check("sram_addr", sram_addr, exp_addr(issued));
            issued++;
         end
         if (prev_done) check("busy_after_done", busy, 0);
         if (prev_stall) begin
            check("stall_valid", pix_valid, 1);
            check("stall_hold", word, prev_word);
         end
         if (pix_valid && pix_ready) begin
            k = popped;
            if (k < NPIX) begin
               expw = {k == NPIX - 1, (k % W) == W - 1, k == 0, mem[exp_addr(k)]};
               check("pixel", word, expw);
               check("done_at_eof", done, k == NPIX - 1);
            end else begin
               check("extra_pixel", k, NPIX - 1);
            end
            popped++;
         end else begin
            check("done_no_pop", done, 0);
         end
         if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cur_cyc;
         end
         prev_done  = done;
         prev_stall = pix_valid && !pix_ready;
         prev_word  = word;
      end
   end

   function automatic logic ready_for(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         2:       return 1'($urandom_range(0, 1));
         default: return cyc >= 20;
      endcase
   endfunction

   task automatic reset_model(input bit hfl);
      issued = 0; popped = 0; done_cnt = 0; done_cyc = -1; cur_cyc = 0;
      prev_done = 0; prev_stall = 0; prev_word = '0;
`ifdef SRAM_FRAME_READER_HFLIP_EN
      hf = hfl;
      hflip = hfl;
`else
      hf = 1'b0;
      if (hfl) hf = 1'b0;
`endif
   endtask

   task automatic run_frame(input int mode, input int restart_cyc, input bit hfl,
                            input int exp_npix, input int exp_ndone,
                            input int exp_first_valid, input int exp_done_cyc);
      int cyc, first_valid, first_en, tail;
      reset_model(hfl);
      @(posedge clk); #1;
      start = 1'b1; pix_ready = ready_for(mode, 0); mon_on = 1'b1;
      cyc = 0; first_valid = -1; first_en = -1; tail = -1;
      while (cyc < 400 && tail < 3) begin
         @(negedge clk);
         if (pix_valid && first_valid < 0) first_valid = cyc;
         if (sram_en && first_en < 0) first_en = cyc;
         @(posedge clk); #1;
         cyc++;
         cur_cyc = cyc;
         if (mode == 3 && cyc == 20) begin
            check("stall_reads", issued, DEPTH);
            check("stall_popped", popped, 0);
            check("stall_full_valid", pix_valid, 1);
         end
`ifdef SRAM_FRAME_READER_HFLIP_EN
         if (cyc == 4) hflip = ~hflip;
`endif
         start = (cyc == restart_cyc);
         pix_ready = ready_for(mode, cyc);
         if (done_cnt > 0) tail++;
      end
      start = 1'b0;
      mon_on = 1'b0;
      check("frame_completed", done_cnt > 0, 1);
      check("pixel_count", popped, exp_npix);
      check("done_count", done_cnt, exp_ndone);
      check("busy_end", busy, 0);
      if (exp_first_valid >= 0) begin
         check("first_valid_cycle", first_valid, exp_first_valid);
         check("first_en_cycle", first_en, 1);
      end
      if (exp_done_cyc >= 0) check("done_cycle", done_cyc, exp_done_cyc);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_sram_en"}, sram_en, 0);
      check({tag, "_sram_we"}, sram_we, 0);
      check({tag, "_sram_addr"}, sram_addr, 0);
      check({tag, "_pix"}, {pix_valid, pix_sof, pix_eol, pix_eof, pix_data}, 0);
   endtask

   typedef struct {
      int mode;
      int restart;
      bit hfl;
      int exp_npix;
      int exp_ndone;
      int exp_first_valid;
      int exp_done_cyc;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int guard;
      tbl[0] = '{0, 0, 1'b0, NPIX, 1, 3,  NPIX + 2};
      tbl[1] = '{1, 0, 1'b0, NPIX, 1, -1, -1};
      tbl[2] = '{3, 0, 1'b0, NPIX, 1, -1, -1};
      tbl[3] = '{0, 5, 1'b0, NPIX, 1, 3,  NPIX + 2};
      tbl[4] = '{2, 0, 1'b0, NPIX, 1, -1, -1};
      tbl[5] = '{2, 7, 1'b0, NPIX, 1, -1, -1};
      tbl[6] = '{0, 0, 1'b1, NPIX, 1, 3,  NPIX + 2};

      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
`ifdef SRAM_FRAME_READER_HFLIP_EN
      hflip = 1'b0;
`endif
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_busy", busy, 0);

      for (int i = 0; i < 7; i++)
         run_frame(tbl[i].mode, tbl[i].restart, tbl[i].hfl, tbl[i].exp_npix,
                   tbl[i].exp_ndone, tbl[i].exp_first_valid, tbl[i].exp_done_cyc);

      // Reset in the middle of a frame: abandon, then a clean frame follows.
      reset_model(1'b0);
      @(posedge clk); #1;
      start = 1'b1; pix_ready = 1'b1; mon_on = 1'b1;
      guard = 0;
      while (popped < 6 && guard < 100) begin
         @(posedge clk); #1;
         start = 1'b0;
         guard++;
      end
      check("mid_reset_reached", popped, 6);
      mon_on = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      check("mid_reset_no_done", done_cnt, 0);
      @(negedge clk);
      @(negedge clk);
      check_all_zero("held_reset");
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      run_frame(0, 0, 1'b0, NPIX, 1, 3, NPIX + 2);

      // Random backpressure across several more frames.
      for (int i = 0; i < 4; i++)
         run_frame(2, 0, 1'b0, NPIX, 1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
